// File: rtl/alu_arbiter_if.sv
// Bundle of the two requester ports, the shared-ALU port and the response port of alu_arbiter.
// slave: the arbiter side. master: the requesters, ALU and response consumer side.
interface alu_arbiter_if #(
   parameter int unsigned XLEN = 32
);
   logic            req0_valid;
   logic            req0_ready;
   logic [3:0]      req0_op;
   logic [XLEN-1:0] req0_a;
   logic [XLEN-1:0] req0_b;

   logic            req1_valid;
   logic            req1_ready;
   logic [3:0]      req1_op;
   logic [XLEN-1:0] req1_a;
   logic [XLEN-1:0] req1_b;

   logic [3:0]      alu_op;
   logic [XLEN-1:0] alu_in1;
   logic [XLEN-1:0] alu_in2;
   logic [XLEN-1:0] alu_result;
   logic            alu_cmp;
   logic            alu_zero;

   logic            rsp_valid;
   logic            rsp_ready;
   logic            rsp_id;
   logic [XLEN-1:0] rsp_result;
   logic            rsp_cmp;
   logic            rsp_zero;

   modport slave (
      input  req0_valid, req0_op, req0_a, req0_b,
      input  req1_valid, req1_op, req1_a, req1_b,
      output req0_ready, req1_ready,
      output alu_op, alu_in1, alu_in2,
      input  alu_result, alu_cmp, alu_zero,
      output rsp_valid, rsp_id, rsp_result, rsp_cmp, rsp_zero,
      input  rsp_ready
   );

   modport master (
      output req0_valid, req0_op, req0_a, req0_b,
      output req1_valid, req1_op, req1_a, req1_b,
      input  req0_ready, req1_ready,
      input  alu_op, alu_in1, alu_in2,
      output alu_result, alu_cmp, alu_zero,
      input  rsp_valid, rsp_id, rsp_result, rsp_cmp, rsp_zero,
      output rsp_ready
   );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a shared combinational ALU.
// One operation in flight: accept -> EXEC (ALU evaluates captured operands) -> RESP (held result).
// Tie-break is round-robin by default; defining ALU_ARB_FIXED_PRIO_EN makes req0 always win.
module alu_arbiter #(
   parameter int unsigned XLEN = 32
) (
   input logic          clk,
   input logic          rst_n,
   alu_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StExec = 2'd1,
      StResp = 2'd2
   } state_e;

   state_e          state_q, state_d;
   logic            accept_ok;
   logic            grant1;
   logic            hs;

   logic [3:0]      op_q;
   logic [XLEN-1:0] a_q;
   logic [XLEN-1:0] b_q;
   logic            id_q;

   logic            rsp_id_q;
   logic [XLEN-1:0] rsp_result_q;
   logic            rsp_cmp_q;
   logic            rsp_zero_q;

`ifdef ALU_ARB_FIXED_PRIO_EN
   // Grant req1 only when req0 is not asking
   always_comb begin
      grant1 = bus.req1_valid & ~bus.req0_valid;
   end
`else
   logic last_grant_q;

   // Grant req1 when it is alone, or on a tie when req0 was served last
   always_comb begin
      grant1 = bus.req1_valid & (~bus.req0_valid | ~last_grant_q);
   end

   // Remember who won the most recent handshake; reset value makes req0 win the first tie
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant_q <= 1'b1;
      end else if (hs) begin
         last_grant_q <= grant1;
      end
   end
`endif

   // Next-state and accept window
   always_comb begin
      state_d   = state_q;
      accept_ok = 1'b0;
      case (state_q)
         StIdle: accept_ok = 1'b1;
         StExec: state_d = StResp;
         StResp: begin
            accept_ok = bus.rsp_ready;
            if (bus.rsp_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
      hs = accept_ok & (bus.req0_valid | bus.req1_valid);
      if (hs) begin
         state_d = StExec;
      end
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Capture the granted requester's operation on handshake
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q <= '0;
         a_q  <= '0;
         b_q  <= '0;
         id_q <= 1'b0;
      end else if (hs) begin
         op_q <= grant1 ? bus.req1_op : bus.req0_op;
         a_q  <= grant1 ? bus.req1_a : bus.req0_a;
         b_q  <= grant1 ? bus.req1_b : bus.req0_b;
         id_q <= grant1;
      end
   end

   // Register the ALU outputs at the end of EXEC; held until the next EXEC
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_id_q     <= 1'b0;
         rsp_result_q <= '0;
         rsp_cmp_q    <= 1'b0;
         rsp_zero_q   <= 1'b0;
      end else if (state_q == StExec) begin
         rsp_id_q     <= id_q;
         rsp_result_q <= bus.alu_result;
         rsp_cmp_q    <= bus.alu_cmp;
         rsp_zero_q   <= bus.alu_zero;
      end
   end

   // Output drive: readies depend only on state, rsp_ready, valids and arbitration state
   always_comb begin
      bus.req0_ready = accept_ok & bus.req0_valid & ~grant1;
      bus.req1_ready = accept_ok & grant1;
      bus.alu_op     = op_q;
      bus.alu_in1    = a_q;
      bus.alu_in2    = b_q;
      bus.rsp_valid  = (state_q == StResp);
      bus.rsp_id     = rsp_id_q;
      bus.rsp_result = rsp_result_q;
      bus.rsp_cmp    = rsp_cmp_q;
      bus.rsp_zero   = rsp_zero_q;
   end

endmodule
